// File: rtl/cardinal_dump_pkg.sv
// Shared types and defaults for the Cardinal DMEM read-back engine.
// FSM encoding, size defaults and the checksum-beat index constant.
package cardinal_dump_pkg;

    localparam int DEPTH_DEF = 128;
    localparam int AW_DEF    = 8;
    localparam int DW_DEF    = 64;

    // The checksum beat is tagged with an all-ones index so a sink can tell it from data.
    localparam logic [0:AW_DEF-1] CHK_INDEX = '1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_READ = 3'd1,
        ST_WAIT = 3'd2,
        ST_SEND = 3'd3,
        ST_CHK  = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    function automatic logic owns_port(input state_t s);
        return (s == ST_READ) || (s == ST_WAIT) || (s == ST_SEND) || (s == ST_CHK);
    endfunction

endpackage

// File: rtl/cardinal_dmem_dump_if.sv
// Bundle of CPU data port, DMEM port, dump stream and status for one dump engine.
// master = the engine, slave = the surrounding CPU / DMEM / sink.
interface cardinal_dmem_dump_if #(
    parameter int AW = 8,
    parameter int DW = 64
);
    logic          start;

    logic          cpu_memEn;
    logic          cpu_memWrEn;
    logic [0:AW-1] cpu_addr;
    logic [0:DW-1] cpu_dout;
    logic [0:DW-1] cpu_din;

    logic          mem_memEn;
    logic          mem_memWrEn;
    logic [0:AW-1] mem_addr;
    logic [0:DW-1] mem_dataIn;
    logic [0:DW-1] mem_dataOut;

    logic          dump_valid;
    logic          dump_ready;
    logic [0:AW-1] dump_index;
    logic [0:DW-1] dump_data;
    logic          dump_last;

    logic          busy;
    logic          done;

    modport master (
        input  start,
        input  cpu_memEn, cpu_memWrEn, cpu_addr, cpu_dout,
        output cpu_din,
        output mem_memEn, mem_memWrEn, mem_addr, mem_dataIn,
        input  mem_dataOut,
        output dump_valid, dump_index, dump_data, dump_last,
        input  dump_ready,
        output busy, done
    );

    modport slave (
        output start,
        output cpu_memEn, cpu_memWrEn, cpu_addr, cpu_dout,
        input  cpu_din,
        input  mem_memEn, mem_memWrEn, mem_addr, mem_dataIn,
        output mem_dataOut,
        input  dump_valid, dump_index, dump_data, dump_last,
        output dump_ready,
        input  busy, done
    );

endinterface

// File: rtl/cardinal_dmem_dump_mux.sv
// DMEM port ownership mux: CPU passthrough when idle, engine-only read port while dumping.
// Purely combinational; the locked-out CPU sees zero load data and its requests are dropped.
module dmem_port_mux #(
    parameter int AW = 8,
    parameter int DW = 64
) (
    input  logic          owner_eng,
    input  logic          eng_memEn,
    input  logic [0:AW-1] eng_addr,

    input  logic          cpu_memEn,
    input  logic          cpu_memWrEn,
    input  logic [0:AW-1] cpu_addr,
    input  logic [0:DW-1] cpu_dout,
    output logic [0:DW-1] cpu_din,

    output logic          mem_memEn,
    output logic          mem_memWrEn,
    output logic [0:AW-1] mem_addr,
    output logic [0:DW-1] mem_dataIn,
    input  logic [0:DW-1] mem_dataOut
);

    always_comb begin
        mem_memEn   = cpu_memEn;
        mem_memWrEn = cpu_memWrEn;
        mem_addr    = cpu_addr;
        mem_dataIn  = cpu_dout;
        cpu_din     = mem_dataOut;
        if (owner_eng) begin
            mem_memEn   = eng_memEn;
            mem_memWrEn = 1'b0;
            mem_addr    = eng_addr;
            mem_dataIn  = '0;
            cpu_din     = '0;
        end
    end

endmodule

// File: rtl/cardinal_dmem_dump.sv
// Reads DMEM[0..DEPTH-1] on a start pulse and streams {index, data} beats; optional XOR
// checksum beat under DMEM_DUMP_CHECKSUM_EN. 3 cycles/word (READ, WAIT, SEND); SEND holds until ready.
module cardinal_dmem_dump
    import cardinal_dump_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF
) (
    input  logic                CLK,
    input  logic                RESET,
    cardinal_dmem_dump_if.master bus
);

    localparam logic [0:AW-1] LAST_PTR = AW'(DEPTH - 1);

    state_t        state, state_nxt;
    logic [0:AW-1] ptr;
    logic          valid_q, last_q, busy_q, done_q;
    logic [0:AW-1] idx_q;
    logic [0:DW-1] data_q;
    logic          start_acc, hs, at_last, eng_en;

`ifdef DMEM_DUMP_CHECKSUM_EN
    localparam logic [0:AW-1] CHK_IDX = {AW{CHK_INDEX[0]}};
    logic [0:DW-1] csum;
`endif

    assign start_acc = ((state == ST_IDLE) || (state == ST_DONE)) && bus.start;
    assign hs        = valid_q && bus.dump_ready;
    assign at_last   = (ptr == LAST_PTR);
    assign eng_en    = (state == ST_READ);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: if (bus.start) state_nxt = ST_READ;
            ST_READ:          state_nxt = ST_WAIT;
            ST_WAIT:          state_nxt = ST_SEND;
            ST_SEND: begin
                if (hs) begin
                    if (!at_last) begin
                        state_nxt = ST_READ;
                    end else begin
`ifdef DMEM_DUMP_CHECKSUM_EN
                        state_nxt = ST_CHK;
`else
                        state_nxt = ST_DONE;
`endif
                    end
                end
            end
            ST_CHK:           if (hs) state_nxt = ST_DONE;
            default:          state_nxt = ST_IDLE;
        endcase
    end

    // Status and stream qualifiers are registered from the next state so they line up with it.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state   <= ST_IDLE;
            ptr     <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            idx_q   <= '0;
            data_q  <= '0;
`ifdef DMEM_DUMP_CHECKSUM_EN
            csum    <= '0;
`endif
        end else begin
            state   <= state_nxt;
            valid_q <= (state_nxt == ST_SEND) || (state_nxt == ST_CHK);
            busy_q  <= owns_port(state_nxt);
            done_q  <= (state_nxt == ST_DONE);
`ifdef DMEM_DUMP_CHECKSUM_EN
            last_q  <= (state_nxt == ST_CHK);
`else
            last_q  <= (state_nxt == ST_SEND) && at_last;
`endif
            if (start_acc) begin
                ptr <= '0;
            end else if ((state == ST_SEND) && hs && !at_last) begin
                ptr <= ptr + AW'(1);
            end
            if (state == ST_WAIT) begin
                data_q <= bus.mem_dataOut;
                idx_q  <= ptr;
            end
`ifdef DMEM_DUMP_CHECKSUM_EN
            if (start_acc) begin
                csum <= '0;
            end else if (state == ST_WAIT) begin
                csum <= csum ^ bus.mem_dataOut;
            end
            if ((state == ST_SEND) && hs && at_last) begin
                idx_q  <= CHK_IDX;
                data_q <= csum;
            end
`endif
        end
    end

    dmem_port_mux #(.AW(AW), .DW(DW)) u_port_mux (
        .owner_eng   (busy_q),
        .eng_memEn   (eng_en),
        .eng_addr    (ptr),
        .cpu_memEn   (bus.cpu_memEn),
        .cpu_memWrEn (bus.cpu_memWrEn),
        .cpu_addr    (bus.cpu_addr),
        .cpu_dout    (bus.cpu_dout),
        .cpu_din     (bus.cpu_din),
        .mem_memEn   (bus.mem_memEn),
        .mem_memWrEn (bus.mem_memWrEn),
        .mem_addr    (bus.mem_addr),
        .mem_dataIn  (bus.mem_dataIn),
        .mem_dataOut (bus.mem_dataOut)
    );

    assign bus.dump_valid = valid_q;
    assign bus.dump_index = idx_q;
    assign bus.dump_data  = data_q;
    assign bus.dump_last  = last_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_cardinal_dmem_dump.sv
// Directed bench for cardinal_dmem_dump with a registered-read DMEM model.
module tb_cardinal_dmem_dump;
    import cardinal_dump_pkg::*;

    localparam int DEPTH = 128;
    localparam int AW    = 8;
    localparam int DW    = 64;
`ifdef DMEM_DUMP_CHECKSUM_EN
    localparam int   EXP_BEATS = DEPTH + 1;
    localparam int   EXP_DONE  = 3 * DEPTH + 2;
    localparam logic LAST127   = 1'b0;
`else
    localparam int   EXP_BEATS = DEPTH;
    localparam int   EXP_DONE  = 3 * DEPTH + 1;
    localparam logic LAST127   = 1'b1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cardinal_dmem_dump_if #(.AW(AW), .DW(DW)) bus ();
    cardinal_dmem_dump #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (.CLK(clk), .RESET(rst), .bus(bus));

    logic [0:DW-1] dmem [256];
    logic          fill_req  = 1'b0;
    int            fill_mode = 0;

    function automatic logic [63:0] pat(input int i);
        return 64'h1000_0000_0000_0000 + 64'(i);
    endfunction

    always @(posedge clk) begin
        if (fill_req) begin
            for (int i = 0; i < 256; i++)
                dmem[i] <= (fill_mode == 0) ? pat(i) : ((i == 5) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0);
        end else if (bus.mem_memEn) begin
            if (bus.mem_memWrEn) dmem[bus.mem_addr] <= bus.mem_dataIn;
            else                 bus.mem_dataOut    <= dmem[bus.mem_addr];
        end
    end

    typedef struct {
        int          beat;
        logic [7:0]  idx;
        logic [63:0] data;
        logic        last;
        int          cyc;
    } vec_t;
    vec_t tbl [6];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int done_cyc, viol;
    int          b_cyc [$];
    logic [7:0]  b_idx [$];
    logic [63:0] b_dat [$];
    logic        b_last[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        cyc = 1;
    endtask

    task automatic cpu_idle();
        bus.cpu_memEn   = 1'b0;
        bus.cpu_memWrEn = 1'b0;
        bus.cpu_addr    = '0;
        bus.cpu_dout    = '0;
    endtask

    task automatic run_capture(input int bound, input bit lock_wr);
        b_cyc.delete(); b_idx.delete(); b_dat.delete(); b_last.delete();
        done_cyc = -1;
        viol     = 0;
        for (int c = 0; c < bound; c++) begin
            if (bus.dump_valid && bus.dump_ready) begin
                b_cyc.push_back(cyc);
                b_idx.push_back(bus.dump_index);
                b_dat.push_back(bus.dump_data);
                b_last.push_back(bus.dump_last);
            end
            if (bus.busy && (bus.mem_memWrEn || (bus.cpu_din != '0))) viol++;
            if (bus.done) begin
                done_cyc = cyc;
                break;
            end
            if (lock_wr) begin
                bus.cpu_memEn   = 1'b1;
                bus.cpu_memWrEn = 1'b1;
                bus.cpu_addr    = 8'd5;
                bus.cpu_dout    = 64'hDEAD;
            end
            tick();
        end
        cpu_idle();
        chk("dump_completes", 64'(done_cyc >= 0), 64'd1);
    endtask

    task automatic wait_beat(input logic [7:0] want, input int bound);
        int c;
        for (c = 0; c < bound; c++) begin
            if (bus.dump_valid && (bus.dump_index == want)) break;
            tick();
        end
        chk("wait_beat", 64'(c < bound), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, errs, lasts;

        tbl[0] = '{0,   8'd0,   64'h1000_0000_0000_0000, 1'b0,    3};
        tbl[1] = '{1,   8'd1,   64'h1000_0000_0000_0001, 1'b0,    6};
        tbl[2] = '{2,   8'd2,   64'h1000_0000_0000_0002, 1'b0,    9};
        tbl[3] = '{64,  8'd64,  64'h1000_0000_0000_0040, 1'b0,    195};
        tbl[4] = '{126, 8'd126, 64'h1000_0000_0000_007E, 1'b0,    381};
        tbl[5] = '{127, 8'd127, 64'h1000_0000_0000_007F, LAST127, 384};

        bus.start      = 1'b0;
        bus.dump_ready = 1'b1;
        cpu_idle();
        fill_mode = 0;
        fill_req  = 1'b1;
        tick();
        fill_req  = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        // Reset state and IDLE passthrough
        chk("rst_valid", 64'(bus.dump_valid), 64'd0);
        chk("rst_busy",  64'(bus.busy),       64'd0);
        chk("rst_done",  64'(bus.done),       64'd0);
        chk("rst_last",  64'(bus.dump_last),  64'd0);
        chk("rst_index", 64'(bus.dump_index), 64'd0);
        chk("rst_data",  bus.dump_data,       64'd0);
        bus.cpu_memEn = 1'b1;
        bus.cpu_addr  = 8'd9;
        #1;
        chk("idle_mem_en",   64'(bus.mem_memEn), 64'd1);
        chk("idle_mem_addr", 64'(bus.mem_addr),  64'd9);
        tick();
        chk("idle_cpu_din", bus.cpu_din, 64'h1000_0000_0000_0009);
        cpu_idle();

        // Full dump with CPU write attempts throughout
        pulse_start();
        run_capture(600, 1'b1);
        chk("main_beats",    64'(b_idx.size()), 64'(EXP_BEATS));
        chk("main_done_cyc", 64'(done_cyc),     64'(EXP_DONE));
        chk("lockout_viol",  64'(viol),         64'd0);
        chk("lockout_dmem5", dmem[5],           64'h1000_0000_0000_0005);
        errs  = 0;
        lasts = 0;
        for (int i = 0; i < b_idx.size(); i++) begin
            if (i < DEPTH && (b_idx[i] != 8'(i) || b_dat[i] != pat(i))) errs++;
            if (b_last[i]) lasts++;
        end
        chk("main_seq_errs", 64'(errs),  64'd1 - 64'd1 + 64'(0));
        chk("main_last_cnt", 64'(lasts), 64'd1);
        for (int k = 0; k < 6; k++) begin
            if (tbl[k].beat < b_idx.size()) begin
                chk($sformatf("tbl%0d_idx",  k), 64'(b_idx[tbl[k].beat]),  64'(tbl[k].idx));
                chk($sformatf("tbl%0d_data", k), b_dat[tbl[k].beat],       tbl[k].data);
                chk($sformatf("tbl%0d_last", k), 64'(b_last[tbl[k].beat]), 64'(tbl[k].last));
                chk($sformatf("tbl%0d_cyc",  k), 64'(b_cyc[tbl[k].beat]),  64'(tbl[k].cyc));
            end else begin
                chk($sformatf("tbl%0d_present", k), 64'(b_idx.size()), 64'(tbl[k].beat + 1));
            end
        end
        tick();
        chk("after_busy", 64'(bus.busy), 64'd0);
        chk("after_done", 64'(bus.done), 64'd1);

        // CPU write in DONE reaches DMEM
        bus.cpu_memEn   = 1'b1;
        bus.cpu_memWrEn = 1'b1;
        bus.cpu_addr    = 8'd5;
        bus.cpu_dout    = 64'hDEAD;
        tick();
        cpu_idle();
        chk("done_write", dmem[5], 64'hDEAD);
        fill_req = 1'b1;
        tick();
        fill_req = 1'b0;

        // Backpressure on beat 3
        pulse_start();
        chk("restart_done_clr", 64'(bus.done), 64'd0);
        wait_beat(8'd3, 60);
        bus.dump_ready = 1'b0;
        errs = 0;
        for (int s = 0; s < 5; s++) begin
            tick();
            if (!bus.dump_valid || bus.dump_index != 8'd3 ||
                bus.dump_data != 64'h1000_0000_0000_0003 || bus.mem_memEn) errs++;
        end
        chk("stall_stable", 64'(errs), 64'd0);
        bus.dump_ready = 1'b1;
        n = 0;
        for (int s = 0; s < 20; s++) begin
            tick();
            n++;
            if (bus.dump_valid && bus.dump_index == 8'd4) break;
        end
        chk("release_lat", 64'(n),         64'd3);
        chk("beat4_data",  bus.dump_data,  64'h1000_0000_0000_0004);

        // start while busy is ignored
        wait_beat(8'd10, 60);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int s = 0; s < 20; s++) begin
            if (bus.dump_valid && bus.dump_index != 8'd10) break;
            tick();
        end
        chk("busy_start_next", 64'(bus.dump_index), 64'd11);
        chk("busy_start_busy", 64'(bus.busy),       64'd1);

        // Reset mid-dump
        wait_beat(8'd40, 200);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_valid", 64'(bus.dump_valid), 64'd0);
        chk("mid_rst_index", 64'(bus.dump_index), 64'd0);
        chk("mid_rst_data",  bus.dump_data,       64'd0);
        chk("mid_rst_last",  64'(bus.dump_last),  64'd0);
        chk("mid_rst_busy",  64'(bus.busy),       64'd0);
        chk("mid_rst_done",  64'(bus.done),       64'd0);
        chk("mid_rst_state", 64'(dut.state),      64'(ST_IDLE));
        chk("mid_rst_memen", 64'(bus.mem_memEn),  64'd0);
        pulse_start();
        run_capture(600, 1'b0);
        chk("post_rst_first_idx", (b_idx.size() > 0) ? 64'(b_idx[0]) : 64'hFF, 64'd0);
        chk("post_rst_first_cyc", (b_cyc.size() > 0) ? 64'(b_cyc[0]) : 64'd0,  64'd3);
        chk("post_rst_beats",     64'(b_idx.size()), 64'(EXP_BEATS));

        // start in DONE gives a fresh dump, done held low until it completes
        pulse_start();
        chk("redo_done_clr", 64'(bus.done), 64'd0);
        run_capture(600, 1'b0);
        chk("redo_beats",    64'(b_idx.size()), 64'(EXP_BEATS));
        chk("redo_done_cyc", 64'(done_cyc),     64'(EXP_DONE));

`ifdef DMEM_DUMP_CHECKSUM_EN
        fill_mode = 1;
        fill_req  = 1'b1;
        tick();
        fill_req  = 1'b0;
        pulse_start();
        run_capture(600, 1'b0);
        if (b_idx.size() == DEPTH + 1) begin
            chk("chk_idx",     64'(b_idx[DEPTH]),      64'hFF);
            chk("chk_data",    b_dat[DEPTH],           64'hFFFF_FFFF_FFFF_FFFF);
            chk("chk_last",    64'(b_last[DEPTH]),     64'd1);
            chk("chk_127last", 64'(b_last[DEPTH - 1]), 64'd0);
        end else begin
            chk("chk_beats", 64'(b_idx.size()), 64'(DEPTH + 1));
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
